// File: rtl/iob_eth_rx_deframer_pkg.sv
// Shared constants, FSM state type and small helpers for the iob_eth RX deframer.
package iob_eth_rx_deframer_pkg;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam int          MAC_LEN      = 6;
  localparam int          HDR_LEN      = 14;
  localparam int          FCS_LEN      = 4;
  localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_DROP
  } state_e;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/iob_eth_rx_deframer_if.sv
// Frame-buffer byte write bus; the deframer is the master, the buffer the slave.
interface iob_eth_rx_deframer_if #(
  parameter int BUF_ADDR_W = 11
) ();
  logic                  buf_we;
  logic [BUF_ADDR_W-1:0] buf_addr;
  logic [7:0]            buf_wdata;

  modport master (output buf_we, buf_addr, buf_wdata);
  modport slave  (input  buf_we, buf_addr, buf_wdata);
endinterface

// File: rtl/iob_eth_rx_deframer_crc32.sv
// Byte-wise reflected CRC-32 register with synchronous init and update enable.
module iob_eth_rx_deframer_crc32
  import iob_eth_rx_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    // NOTE: default assignment first so no path leaves crc_d unassigned (no latch).
    crc_d = crc_q;
    if (en_i) begin
      for (int i = 0; i < 8; i++) begin
        crc_d = (crc_d >> 1) ^ (POLY_REFL & {32{crc_d[0] ^ data_i[i]}});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc_q <= CRC_INIT;
    else if (init_i) crc_q <= CRC_INIT;
    else             crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/iob_eth_rx_deframer.sv
// MII RX deframer: nibble->byte assembly, dest-MAC filter, frame-buffer writes, ready/ack.
// Define ETH_RX_CRC_EN to check the FCS with CRC-32; otherwise crc_err_o is tied 0.
module iob_eth_rx_deframer
  import iob_eth_rx_deframer_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR   = 48'h0,
  parameter int          BUF_ADDR_W = 11,
  parameter int          NBYTES_W   = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_dv_i,
  input  logic [3:0]            rx_data_i,
  input  logic [NBYTES_W-1:0]   rx_nbytes_i,
  input  logic                  rcv_ack_i,
  iob_eth_rx_deframer_if.master buf_o,
  output logic                  rx_ready_o,
  output logic                  crc_err_o,
  output logic [15:0]           drop_cnt_o
);
  localparam int               CNT_W     = ((NBYTES_W > BUF_ADDR_W) ? NBYTES_W : BUF_ADDR_W) + 1;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] BUF_SIZE  = ONE << BUF_ADDR_W;
  localparam logic [CNT_W-1:0] FRAME_OVH = CNT_W'(HDR_LEN + FCS_LEN);
  localparam logic [CNT_W-1:0] MAC_LAST  = CNT_W'(MAC_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);

  state_e                state_q;
  logic                  phase_q, armed_q, mac_ok_q, bcast_q, oversize_q;
  logic [3:0]            nib0_q;
  logic [CNT_W-1:0]      cnt_q, end_q;
  logic                  we_q;
  logic [BUF_ADDR_W-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic                  rx_ready_q, crc_err_q;
  logic [15:0]           drop_q;

  logic [7:0]       byte_w;
  logic [5:0]       mac_sh;
  logic [CNT_W-1:0] frame_len;
  logic             mac_ok_d, bcast_d, start_hit, sfd_hit, overrun, too_big, crc_bad;

  assign byte_w    = {rx_data_i, nib0_q};
  assign mac_sh    = {3'd5 - cnt_q[2:0], 3'b000};
  assign mac_ok_d  = mac_ok_q && (byte_w == 8'(MAC_ADDR >> mac_sh));
  assign bcast_d   = bcast_q && (byte_w == 8'(BCAST_MAC >> mac_sh));
  assign start_hit = armed_q && rx_dv_i && (rx_data_i == PREAMBLE_NIB);
  assign sfd_hit   = (state_q == ST_PREAMBLE) && rx_dv_i && (rx_data_i == SFD_NIB);
  // A pending frame not acked this cycle must not be overwritten.
  assign overrun   = rx_ready_q && !rcv_ack_i;
  assign frame_len = CNT_W'(rx_nbytes_i) + FRAME_OVH;
  assign too_big   = frame_len > BUF_SIZE;

`ifdef ETH_RX_CRC_EN
  logic [31:0] crc;

  iob_eth_rx_deframer_crc32 u_crc32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (sfd_hit),
    .en_i   (we_q),
    .data_i (wdata_q),
    .crc_o  (crc)
  );

  assign crc_bad = (bitrev32(crc) != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      armed_q    <= 1'b0;
      mac_ok_q   <= 1'b0;
      bcast_q    <= 1'b0;
      oversize_q <= 1'b0;
      nib0_q     <= '0;
      cnt_q      <= '0;
      end_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      crc_err_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (!rx_dv_i) armed_q <= 1'b1;
      if (rcv_ack_i) begin
        rx_ready_q <= 1'b0;
        crc_err_q  <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: if (start_hit) state_q <= ST_PREAMBLE;
        ST_DONE: begin
          if (start_hit)      state_q <= ST_PREAMBLE;
          else if (rcv_ack_i) state_q <= ST_IDLE;
        end
        ST_PREAMBLE: begin
          if (sfd_hit) begin
            armed_q    <= 1'b0;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            mac_ok_q   <= 1'b1;
            bcast_q    <= 1'b1;
            oversize_q <= too_big;
            end_q      <= too_big ? BUF_SIZE - ONE : frame_len - ONE;
            state_q    <= overrun ? ST_DROP : ST_HEADER;
          end else if (!rx_dv_i || rx_data_i != PREAMBLE_NIB) begin
            state_q <= ST_IDLE;
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          // Completion wins over rx_dv so a frame ending on the last nibble is not truncated.
          if (cnt_q > end_q) begin
            state_q <= oversize_q ? ST_DROP : ST_CHECK;
          end else if (!rx_dv_i) begin
            drop_q  <= sat_inc16(drop_q);
            state_q <= ST_IDLE;
          end else if (!phase_q) begin
            nib0_q  <= rx_data_i;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= cnt_q[BUF_ADDR_W-1:0];
            wdata_q <= byte_w;
            cnt_q   <= cnt_q + ONE;
            if (state_q == ST_HEADER) begin
              if (cnt_q <= MAC_LAST) begin
                mac_ok_q <= mac_ok_d;
                bcast_q  <= bcast_d;
              end
              if (cnt_q == MAC_LAST && !(mac_ok_d || bcast_d)) state_q <= ST_DROP;
              else if (cnt_q == HDR_LAST)                      state_q <= ST_PAYLOAD;
            end
          end
        end
        ST_CHECK: begin
          rx_ready_q <= 1'b1;
          crc_err_q  <= crc_bad;
          state_q    <= ST_DONE;
        end
        ST_DROP: begin
          if (!rx_dv_i) begin
            drop_q  <= sat_inc16(drop_q);
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign buf_o.buf_we    = we_q;
  assign buf_o.buf_addr  = addr_q;
  assign buf_o.buf_wdata = wdata_q;
  assign rx_ready_o      = rx_ready_q;
  assign crc_err_o       = crc_err_q;
  assign drop_cnt_o      = drop_q;
endmodule

// File: tb/tb_iob_eth_rx_deframer.sv
// Directed bench for iob_eth_rx_deframer: frame-buffer writes checked against a scoreboard queue.
module tb_iob_eth_rx_deframer;
  localparam logic [47:0] MAC_ADDR = 48'h0200_0000_00AA;
  localparam logic [47:0] SRC_MAC  = 48'h0200_0000_0002;
  localparam logic [47:0] BAD_MAC  = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;
  localparam int          NBYTES   = 238;
  localparam int          FRAME_SZ = 14 + NBYTES + 4;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [3:0]  rx_data = 4'h0;
  logic [10:0] rx_nbytes = 11'(NBYTES);
  logic        rcv_ack = 1'b0;
  logic        rx_ready, crc_err;
  logic [15:0] drop_cnt;

  int   checks = 0;
  int   failures = 0;
  int   exp_drop = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] mem [0:2047];

  iob_eth_rx_deframer_if #(.BUF_ADDR_W(11)) bus ();

  iob_eth_rx_deframer #(
    .MAC_ADDR   (MAC_ADDR),
    .BUF_ADDR_W (11),
    .NBYTES_W   (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_dv_i     (rx_dv),
    .rx_data_i   (rx_data),
    .rx_nbytes_i (rx_nbytes),
    .rcv_ack_i   (rcv_ack),
    .buf_o       (bus),
    .rx_ready_o  (rx_ready),
    .crc_err_o   (crc_err),
    .drop_cnt_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every buffer write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus.buf_we === 1'b1) begin
      mem[bus.buf_addr] = bus.buf_wdata;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed addr=%0d data=%0h expected no write",
               bus.buf_addr, bus.buf_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert ({bus.buf_addr, bus.buf_wdata} === mon_e) else begin
          failures++;
          $error("FAIL wr_data observed addr=%0d data=%0h expected addr=%0d data=%0h",
                 bus.buf_addr, bus.buf_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  function automatic logic [31:0] fcs32(input logic [7:0] d[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c ^= {24'h0, d[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    rcv_ack = 1'b0;
    rx_dv   = 1'b1;
    rx_data = n;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_dv   = 1'b0;
      rcv_ack = 1'b0;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    rx_dv   = 1'b0;
    rcv_ack = 1'b1;
    @(negedge clk);
    rcv_ack = 1'b0;
  endtask

  // n_send: frame bytes transmitted (<0 = all); n_exp: leading bytes expected in the buffer.
  task automatic send_frame(input logic [47:0] dest, input string msg, input bit flip,
                            input int n_send, input int n_exp, input bit ack_start,
                            input bit chg_nb);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    int          n;
    for (int i = 0; i < 6; i++) fr.push_back(dest[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(SRC_MAC[8*(5-i) +: 8]);
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    for (int i = 0; i < NBYTES; i++) fr.push_back((i < msg.len()) ? msg[i] : 8'h00);
    fcs = fcs32(fr);
    for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
    if (flip) fr[17] = fr[17] ^ 8'h04;
    n = (n_send < 0) ? fr.size() : n_send;
    rx_nbytes = 11'(NBYTES);
    for (int i = 0; i < 32; i++) begin
      nib((i == 31) ? 4'hD : 4'h5);
      if (i == 0 && ack_start) rcv_ack = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      if (chg_nb && i == 30) rx_nbytes = 11'd60;
      nib(fr[i][3:0]);
      if (i < n_exp) exp_q.push_back('{addr: 11'(i), data: fr[i]});
      nib(fr[i][7:4]);
    end
  endtask

  // Last FCS nibble was just driven; rx_ready must rise exactly two cycles after it is sampled.
  task automatic tail(input string tag, input bit exp_err, input bit extra);
    @(negedge clk);
    rx_dv   = extra;
    rx_data = 4'h5;
    @(negedge clk);
    check({tag, "_ready_early"}, rx_ready, 0);
    rx_data = 4'hD;
    @(negedge clk);
    check({tag, "_ready"}, rx_ready, 1);
    check({tag, "_crc_err"}, crc_err, exp_err);
    rx_data = 4'h5;
    idle(4);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_msg(input string tag, input string msg);
    for (int i = 0; i < msg.len(); i++) check(tag, mem[14+i], msg[i]);
  endtask

  initial begin
    bit exp_flip_err;
`ifdef ETH_RX_CRC_EN
    exp_flip_err = 1'b1;
`else
    exp_flip_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_buf_we", bus.buf_we, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_crc_err", crc_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    idle(4);
    ack();
    check("ack_while_idle", rx_ready, 0);

    // Good frame with trailing nibbles kept on the line after the FCS.
    send_frame(MAC_ADDR, "Hello from PC!", 0, -1, FRAME_SZ, 0, 0);
    tail("good", 0, 1);
    check_msg("good_payload", "Hello from PC!");
    check("good_drop_cnt", drop_cnt, exp_drop);
    ack();
    check("good_ack_clears", rx_ready, 0);
    idle(3);

    send_frame(MAC_ADDR, "Hello from PC!", 1, -1, FRAME_SZ, 0, 0);
    tail("flip", exp_flip_err, 0);
    ack();
    check("flip_ack_clears_err", crc_err, 0);
    idle(3);

    send_frame(BAD_MAC, "Hello from PC!", 0, -1, 6, 0, 0);
    idle(4);
    exp_drop++;
    check("mac_drop_cnt", drop_cnt, exp_drop);
    check("mac_no_ready", rx_ready, 0);
    check("mac_sb_empty", exp_q.size(), 0);

    send_frame(BCAST, "Hello from PC!", 0, -1, FRAME_SZ, 0, 0);
    tail("bcast", 0, 0);

    send_frame(MAC_ADDR, "Overrun frame!", 0, -1, 0, 0, 0);
    idle(4);
    exp_drop++;
    check("ovr_drop_cnt", drop_cnt, exp_drop);
    check("ovr_ready_held", rx_ready, 1);
    check("ovr_sb_empty", exp_q.size(), 0);
    check_msg("ovr_buf_kept", "Hello from PC!");

    // Ack coincides with the first preamble nibble; rx_nbytes changes mid-frame.
    send_frame(MAC_ADDR, "Third frame ok", 0, -1, FRAME_SZ, 1, 1);
    tail("third", 0, 0);
    check_msg("third_payload", "Third frame ok");
    ack();
    idle(2);

    send_frame(MAC_ADDR, "Truncated!", 0, 34, 34, 0, 0);
    idle(4);
    exp_drop++;
    check("trunc_drop_cnt", drop_cnt, exp_drop);
    check("trunc_no_ready", rx_ready, 0);
    check("trunc_sb_empty", exp_q.size(), 0);
    send_frame(MAC_ADDR, "After trunc!!!", 0, -1, FRAME_SZ, 0, 0);
    tail("post_trunc", 0, 0);
    check_msg("post_trunc_payload", "After trunc!!!");
    ack();
    idle(2);

    send_frame(MAC_ADDR, "Reset victim", 0, 40, 40, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_buf_we", bus.buf_we, 0);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_crc_err", crc_err, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_sb_empty", exp_q.size(), 0);
    exp_drop = 0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    send_frame(MAC_ADDR, "Hello again!!!", 0, -1, FRAME_SZ, 0, 0);
    tail("post_rst", 0, 0);
    check_msg("post_rst_payload", "Hello again!!!");
    check("post_rst_drop_cnt", drop_cnt, exp_drop);
    ack();
    check("post_rst_ack", rx_ready, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
